// File: rtl/dsp48a1_mac_seq_pkg.sv
// Package shared by the DSP48A1 MAC sequencer files.
// Holds the slice pipeline depth, the OPMODE codes and the FSM state encoding.
// OPMODE bit layout: [1:0] X mux (01 = M), [3:2] Z mux (00 = 0, 10 = P, 11 = C).
package mac_seq_pkg;
  localparam int PIPE_LAT = 4;             // handshake edge -> P capture edge is PIPE_LAT-1 edges later
  localparam int STAGES   = PIPE_LAT - 2;  // top index of the valid delay line (v[0..2])

  localparam logic [7:0] OPM_IDLE       = 8'h00;
  localparam logic [7:0] OPM_FIRST      = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC        = 8'h09;  // P = M + P
  localparam logic [7:0] OPM_FIRST_BIAS = 8'h0D;  // P = M + C

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/dsp48a1_mac_seq_if.sv
// Request/operand/result bundle between a job source and the MAC sequencer.
// master: job source (drives start/len/operands, consumes result).
// slave : sequencer.
// Optional macro MAC_BIAS_EN adds a 48-bit bias sampled with the job start.
interface dsp48a1_mac_seq_if #(parameter int LEN_W = 10);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
`ifdef MAC_BIAS_EN
  logic [47:0]      bias;
`endif

  modport master (
`ifdef MAC_BIAS_EN
    output bias,
`endif
    output start, len, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_data
  );

  modport slave (
`ifdef MAC_BIAS_EN
    input  bias,
`endif
    input  start, len, in_valid, in_a, in_b, res_ready,
    output busy, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp48a1_mac_seq_align.sv
// Valid/first delay line that lines the slice controls up with the A/B pipeline.
// Ports: clk, RST (sync, active high); hs = operand handshake this cycle,
//   hs_first = that handshake carries the first pair of the job;
//   cep/opmode drive the slice; last_out = the newest product is being captured
//   into P this cycle with nothing younger behind it.
// Macro MAC_BIAS_EN selects the Z=C opcode for the first pair.
module mac_seq_align
  import mac_seq_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       hs,
  input  logic       hs_first,
  output logic       cep,
  output logic [7:0] opmode,
  output logic       last_out
);
`ifdef MAC_BIAS_EN
  localparam logic [7:0] OPM_START = OPM_FIRST_BIAS;
`else
  localparam logic [7:0] OPM_START = OPM_FIRST;
`endif

  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] first_pipe;

  always_ff @(posedge clk) begin
    if (RST) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], hs};
      first_pipe <= {first_pipe[STAGES-1:0], hs & hs_first};
    end
  end

  // OPMODE is registered inside the slice, so it is presented one stage ahead of CEP.
  assign opmode   = vld_pipe[STAGES-1] ? (first_pipe[STAGES-1] ? OPM_START : OPM_ACC) : OPM_IDLE;
  assign cep      = vld_pipe[STAGES];
  assign last_out = vld_pipe[STAGES] & ~|vld_pipe[STAGES-1:0];
endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Sequencer running one DSP48A1 slice as a multiply-accumulate engine.
// Ports: clk, RST (sync, active high); bus (slave side of dsp48a1_mac_seq_if:
//   start/len job request, in_valid/in_ready/in_a/in_b operands,
//   res_valid/res_ready/res_data result, busy); dsp_A/B/C/OPMODE/CEP/RSTP to
//   the slice, dsp_P from it.
// Macro MAC_BIAS_EN: bias sampled at job start, driven on dsp_C and added by
//   the first pair (or returned directly for an empty job).
module dsp48a1_mac_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 10
)(
  input  logic              clk,
  input  logic              RST,
  dsp48a1_mac_seq_if.slave  bus,
  output logic [17:0]       dsp_A,
  output logic [17:0]       dsp_B,
  output logic [47:0]       dsp_C,
  output logic [7:0]        dsp_OPMODE,
  output logic              dsp_CEP,
  output logic              dsp_RSTP,
  input  logic [47:0]       dsp_P
);
  state_e           state, state_nxt;
  logic [LEN_W-1:0] cnt;         // pairs still to be accepted
  logic             first_pend;  // next handshake is the job's first pair
  logic             zero_job;    // current result comes from an empty job, not from P
  logic [47:0]      bias_q;
  logic             hs, accept, drain_done, last_out;

  assign accept = (state == S_IDLE) & bus.start;
  assign hs     = bus.in_valid & (state == S_FEED);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? S_DONE : S_FEED;
      S_FEED:  if (hs && cnt == LEN_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_DONE;
      S_DONE:  if (bus.res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      first_pend <= 1'b0;
      zero_job   <= 1'b0;
      bias_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= bus.len;
        first_pend <= 1'b1;
        zero_job   <= (bus.len == '0);
`ifdef MAC_BIAS_EN
        bias_q     <= bus.bias;
`endif
      end else if (hs) begin
        cnt        <= cnt - LEN_W'(1);
        first_pend <= 1'b0;
      end
    end
  end

  mac_seq_align u_align (
    .clk      (clk),
    .RST      (RST),
    .hs       (hs),
    .hs_first (first_pend),
    .cep      (dsp_CEP),
    .opmode   (dsp_OPMODE),
    .last_out (last_out)
  );

  // In DRAIN no new pairs enter, so an isolated v[2] is the last pair landing in P.
  assign drain_done = (state == S_DRAIN) & last_out;

  assign bus.busy      = (state != S_IDLE);
  assign bus.in_ready  = (state == S_FEED);
  assign bus.res_valid = (state == S_DONE);
  // An empty job never touches the slice, so P may still hold an older result.
  assign bus.res_data  = zero_job ? bias_q : dsp_P;

  assign dsp_A    = bus.in_a;
  assign dsp_B    = bus.in_b;
  assign dsp_C    = bias_q;
  assign dsp_RSTP = RST;
endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
module tb_dsp48a1_mac_seq;
  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  dsp48a1_mac_seq_if #(.LEN_W(10)) bus ();

  logic [17:0] dsp_A, dsp_B;
  logic [47:0] dsp_C, dsp_P;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CEP, dsp_RSTP;

  dsp48a1_mac_seq #(.LEN_W(10)) dut (
    .clk(clk), .RST(RST), .bus(bus),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C), .dsp_OPMODE(dsp_OPMODE),
    .dsp_CEP(dsp_CEP), .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P)
  );

  // Slice model: A0/B0 -> A1/B1 -> M -> P, OPMODE register, X/Z muxes.
  logic signed [17:0] a0, b0, a1, b1;
  logic signed [35:0] m;
  logic [7:0]  opm_r;
  logic [47:0] p, xm, zm;
  always_comb begin
    xm = (opm_r[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
    case (opm_r[3:2])
      2'b10:   zm = p;
      2'b11:   zm = dsp_C;
      default: zm = 48'd0;
    endcase
  end
  always @(posedge clk) begin
    a0 <= dsp_A; b0 <= dsp_B; a1 <= a0; b1 <= b0; m <= a1 * b1;
    opm_r <= dsp_OPMODE;
    if (dsp_RSTP) p <= 48'd0;
    else if (dsp_CEP) p <= xm + zm;
  end
  assign dsp_P = p;

  int cep_total = 0;
  always @(negedge clk) if (dsp_CEP) cep_total++;

  int vecs = 0, errs = 0;
  logic signed [17:0] qa [64];
  logic signed [17:0] qb [64];
  logic [47:0] cur_bias = 48'd0;

  // Reference: sum of signed products, wrapped to 48 bits, plus bias.
  function automatic logic [47:0] model_mac(input int n, input logic [47:0] b);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(qa[i]) * longint'(qb[i]);
    return 48'(acc) + b;
  endfunction

  // Drives one job and measures it; leaves the result un-acknowledged.
  task automatic run_job(input int n, input int gap, input bit rnd_gap,
                         output int lat, output int ceps, output bit to);
    int k, g, c0;
    to = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = 10'(n);
`ifdef MAC_BIAS_EN
    bus.bias = cur_bias;
`endif
    c0 = cep_total;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1; bus.in_a = qa[i]; bus.in_b = qb[i];
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.in_ready) break;
        @(posedge clk);
      end
      if (k == 50) to = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (i != n - 1) begin
        g = rnd_gap ? int'($urandom_range(gap)) : gap;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.res_valid) break;
    end
    lat  = k;
    ceps = cep_total - c0;
  endtask

  task automatic ack();
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
    vecs++; if (dsp_CEP !== 1'b0) begin errs++; $display("FAIL rst_cep got %b want 0", dsp_CEP); end
    vecs++; if (dsp_OPMODE !== 8'h00) begin errs++; $display("FAIL rst_opmode got %h want 00", dsp_OPMODE); end
    vecs++; if (dsp_C !== 48'd0) begin errs++; $display("FAIL rst_c got %h want 0", dsp_C); end
    vecs++; if (dsp_RSTP !== 1'b1) begin errs++; $display("FAIL rst_rstp got %b want 1", dsp_RSTP); end
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    vecs++; if (dsp_RSTP !== 1'b0) begin errs++; $display("FAIL rstp_release got %b want 0", dsp_RSTP); end
  endtask

  task automatic test_back_to_back();
    int lat, ceps; bit to;
    qa[0] = 5; qb[0] = 4; qa[1] = 2; qb[1] = 5; qa[2] = 10; qb[2] = 5;
    run_job(3, 0, 1'b0, lat, ceps, to);
    vecs++; if (to) begin errs++; $display("FAIL b2b_handshake timed out"); end
    vecs++; if (bus.res_data !== 48'd80) begin errs++; $display("FAIL b2b_data got %0d want 80", bus.res_data); end
    vecs++; if (lat !== 4) begin errs++; $display("FAIL b2b_latency got %0d want 4", lat); end
    vecs++; if (ceps !== 3) begin errs++; $display("FAIL b2b_cep got %0d want 3", ceps); end
    ack();
  endtask

  task automatic test_gaps();
    int lat, ceps; bit to;
    qa[0] = 5; qb[0] = 4; qa[1] = 2; qb[1] = 5; qa[2] = 10; qb[2] = 5;
    run_job(3, 2, 1'b0, lat, ceps, to);
    vecs++; if (bus.res_data !== 48'd80 || to) begin errs++; $display("FAIL gap_data got %0d want 80", bus.res_data); end
    vecs++; if (ceps !== 3) begin errs++; $display("FAIL gap_cep got %0d want 3", ceps); end
    vecs++; if (lat !== 4) begin errs++; $display("FAIL gap_latency got %0d want 4", lat); end
    ack();
  endtask

  task automatic test_negative();
    int lat, ceps; bit to;
    qa[0] = -3; qb[0] = 7; qa[1] = 2; qb[1] = 2;
    run_job(2, 0, 1'b0, lat, ceps, to);
    vecs++; if (bus.res_data !== 48'hFFFF_FFFF_FFEF || to) begin errs++; $display("FAIL neg_data got %h want ffffffffffef", bus.res_data); end
    ack();
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1 bus.start = 1'b1; bus.len = 10'd0;
`ifdef MAC_BIAS_EN
    bus.bias = cur_bias;
`endif
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    vecs++; if (bus.res_valid !== 1'b1) begin errs++; $display("FAIL zero_valid got %b want 1", bus.res_valid); end
    vecs++; if (bus.res_data !== cur_bias) begin errs++; $display("FAIL zero_data got %h want %h", bus.res_data, cur_bias); end
    // start while DONE and not acknowledged: stays in DONE
    @(posedge clk); #1 bus.start = 1'b1; bus.len = 10'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    vecs++; if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL busy_start got valid=%b ready=%b want 1 0", bus.res_valid, bus.in_ready); end
    // start in the exiting DONE cycle: must not begin a job
    @(posedge clk); #1 bus.start = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL done_exit_start got busy=%b want 0", bus.busy); end
    bus.in_valid = 1'b1;
    @(negedge clk);
    vecs++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL idle_in_valid got ready=%b want 0", bus.in_ready); end
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, ceps, c0; bit to;
    @(posedge clk); #1 bus.start = 1'b1; bus.len = 10'd4;
    @(posedge clk); #1 bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = 18'd9; bus.in_b = 18'd9;
    c0 = cep_total;
    @(posedge clk); #1 RST = 1'b1;
    @(negedge clk);
    vecs++; if (dsp_RSTP !== 1'b1) begin errs++; $display("FAIL mid_rstp got %b want 1", dsp_RSTP); end
    @(posedge clk); #1 RST = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    vecs++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL mid_idle got busy=%b ready=%b want 0 0", bus.busy, bus.in_ready); end
    vecs++; if (dsp_P !== 48'd0) begin errs++; $display("FAIL mid_p got %h want 0", dsp_P); end
    repeat (5) @(negedge clk);
    vecs++; if (cep_total != c0) begin errs++; $display("FAIL mid_cep got %0d want 0", cep_total - c0); end
    qa[0] = 15; qb[0] = 30;
    run_job(1, 0, 1'b0, lat, ceps, to);
    vecs++; if (bus.res_data !== 48'd450 || to) begin errs++; $display("FAIL mid_next_data got %0d want 450", bus.res_data); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat, ceps; bit to; logic [47:0] first;
    for (int i = 0; i < 3; i++) begin qa[i] = 18'($urandom); qb[i] = 18'($urandom); end
    run_job(3, 0, 1'b0, lat, ceps, to);
    first = bus.res_data;
    vecs++; if (first !== model_mac(3, cur_bias) || to) begin errs++; $display("FAIL bp_data got %h want %h", first, model_mac(3, cur_bias)); end
    repeat (5) begin
      @(negedge clk);
      vecs++; if (bus.res_valid !== 1'b1 || bus.res_data !== first) begin errs++; $display("FAIL bp_hold got valid=%b data=%h want 1 %h", bus.res_valid, bus.res_data, first); end
    end
    ack();
    @(negedge clk);
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL bp_release got %b want 0", bus.res_valid); end
  endtask

  task automatic test_random();
    int lat, ceps, n; bit to;
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) begin qa[i] = 18'($urandom); qb[i] = 18'($urandom); end
      if (j == 0) for (int i = 0; i < n; i++) begin qa[i] = -18'sd131072; qb[i] = -18'sd131072; end
      run_job(n, 2, 1'b1, lat, ceps, to);
      vecs++; if (bus.res_data !== model_mac(n, cur_bias) || to) begin errs++; $display("FAIL rnd%0d_data got %h want %h", j, bus.res_data, model_mac(n, cur_bias)); end
      vecs++; if (lat !== 4 || ceps !== n) begin errs++; $display("FAIL rnd%0d_timing got lat=%0d cep=%0d want 4 %0d", j, lat, ceps, n); end
      ack();
    end
  endtask

`ifdef MAC_BIAS_EN
  task automatic test_bias();
    int lat, ceps; bit to;
    cur_bias = 48'd7;
    qa[0] = 5; qb[0] = 4;
    run_job(1, 0, 1'b0, lat, ceps, to);
    vecs++; if (bus.res_data !== 48'd27 || to) begin errs++; $display("FAIL bias_data got %0d want 27", bus.res_data); end
    ack();
    cur_bias = 48'h8000_0000_1234;
    test_zero_len();
    cur_bias = 48'd0;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.res_ready = 1'b0;
`ifdef MAC_BIAS_EN
    bus.bias = '0;
`endif
    test_reset();
    test_back_to_back();
    test_gaps();
    test_negative();
    test_zero_len();
    test_reset_mid();
    test_backpressure();
    test_random();
`ifdef MAC_BIAS_EN
    test_bias();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached after %0d vectors", vecs);
    $fatal(1, "timeout");
  end
endmodule
